instr_encoder: RTL and testbench



---
 rtl/instr_encoder_pkg.sv | 42 ++++
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder_enc_pack.sv | 46 ++++
 rtl/instr_encoder.sv | 122 ++++++++++++
 tb/tb_instr_encoder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    // Decoded field bundle as held in the first pipeline stage.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the encoder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams.
interface instr_encoder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [WIDTH-1:0] in_imm;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_addr;
    logic             out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder_enc_pack.sv
// Combinational field packer and immediate range checker (IMM_CHECK_EN enables checks).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module enc_pack
    import rv_enc_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] instr,
    output logic        err
);

    // Scatter the immediate into the format-specific bit positions.
    always_comb begin
        instr = NOP_INSTR;
        case (f.fmt)
            FMT_R: instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S: instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B: instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                            f.imm[4:1], f.imm[11], f.opcode};
            FMT_U: instr = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                            f.rd, f.opcode};
            default: instr = NOP_INSTR;
        endcase
    end

`ifdef IMM_CHECK_EN
    // Flag immediates whose discarded high bits are not a pure sign extension.
    always_comb begin
        err = 1'b0;
        case (f.fmt)
            FMT_R: err = 1'b0;
            FMT_I,
            FMT_S: err = !((&f.imm[31:11]) || !(|f.imm[31:11]));
            FMT_B: err = f.imm[0] || !((&f.imm[31:12]) || !(|f.imm[31:12]));
            FMT_J: err = f.imm[0] || !((&f.imm[31:20]) || !(|f.imm[31:20]));
            FMT_U: err = |f.imm[11:0];
            default: err = 1'b1;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: fields in, 32-bit words with sequential byte addresses out.
// Latency: 2 cycles input handshake to out_valid; 1 word/cycle throughput.
// Backpressure: S2 holds while out_valid && !out_ready; in_ready drops once both stages are full.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    instr_encoder_if.slave   bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    enc_state_t       state, state_nxt;
    fields_t          in_f;
    fields_t          s1_f;
    logic             s1_valid;
    logic             s1_last;
    logic             s2_last;
    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic             load_start;
    logic [WIDTH-1:0] addr_cnt;
    logic [31:0]      enc_word;
    logic             enc_err;

    assign in_f = '{fmt:    bus.in_fmt,
                    opcode: bus.in_opcode,
                    rd:     bus.in_rd,
                    rs1:    bus.in_rs1,
                    rs2:    bus.in_rs2,
                    funct3: bus.in_funct3,
                    funct7: bus.in_funct7,
                    imm:    bus.in_imm};

    assign load_start   = (state == ST_IDLE) && start;
    assign s2_load      = !bus.out_valid || bus.out_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;
    assign bus.in_ready = (state == ST_RUN) && (!s1_valid || s2_load);
    assign in_fire      = bus.in_valid && bus.in_ready;

    enc_pack u_pack (
        .f     (s1_f),
        .instr (enc_word),
        .err   (enc_err)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs: the load ends when the last word leaves S2.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (out_fire && s2_last) state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // S1: capture the field bundle; empties when S2 takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_last  <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_f     <= in_f;
            s1_last  <= bus.in_last;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: encoded word plus its address; the address counter advances per loaded word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr  <= BASE_ADDR;
            bus.out_err   <= 1'b0;
            s2_last       <= 1'b0;
            addr_cnt      <= BASE_ADDR;
        end else begin
            if (s2_load) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_instr <= enc_word;
                    bus.out_addr  <= addr_cnt;
                    bus.out_err   <= enc_err;
                    s2_last       <= s1_last;
                    addr_cnt      <= addr_cnt + WIDTH'(4);
                end
            end
            if (load_start) addr_cnt <= BASE_ADDR;
        end
    end

    // Count output handshakes for this load, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst || load_start)                instr_cnt <= '0;
        else if (out_fire && !(&instr_cnt))   instr_cnt <= instr_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: randomized out_ready and directed stalls.
module tb_instr_encoder;
    import rv_enc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef IMM_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] instr_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    instr_encoder_if #(.WIDTH(32)) bus ();

    instr_encoder #(.WIDTH(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic fields_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
        fields_t f;
        f.fmt = fmt; f.opcode = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
        f.funct3 = f3; f.funct7 = f7; f.imm = imm;
        return f;
    endfunction

    // Reference encoding by arithmetic placement of each field.
    function automatic logic [31:0] ref_encode(input fields_t f);
        logic [31:0] u, op, rd, rs1, rs2, f3, f7;
        u = f.imm; op = 32'(f.opcode); rd = 32'(f.rd) << 7; f3 = 32'(f.funct3) << 12;
        rs1 = 32'(f.rs1) << 15; rs2 = 32'(f.rs2) << 20; f7 = 32'(f.funct7) << 25;
        case (f.fmt)
            3'd0: return op | rd | f3 | rs1 | rs2 | f7;
            3'd1: return op | rd | f3 | rs1 | ((u & 32'hfff) << 20);
            3'd2: return op | ((u & 31) << 7) | f3 | rs1 | rs2 | (((u >> 5) & 127) << 25);
            3'd3: return op | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | f3 | rs1 | rs2
                         | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
            3'd4: return op | rd | (u & 32'hffff_f000);
            3'd5: return op | rd | (((u >> 12) & 255) << 12) | (((u >> 11) & 1) << 20)
                         | (((u >> 1) & 1023) << 21) | (((u >> 20) & 1) << 31);
            default: return 32'h0000_0013;
        endcase
    endfunction

    // Reference range check: immediate must fit the signed field range.
    function automatic logic ref_err(input fields_t f);
        int s;
        s = $signed(f.imm);
        if (!CHK) return 1'b0;
        case (f.fmt)
            3'd0: return 1'b0;
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3: return f.imm[0] || (s < -4096) || (s > 4095);
            3'd5: return f.imm[0] || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            3'd4: return (f.imm & 32'hfff) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), $urandom);
        case ($urandom_range(0, 3))
            0: f.imm = $urandom;
            1: f.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: f.imm = $urandom & 32'hffff_f000;
            default: f.imm = (32'($urandom_range(0, 32'h1f_ffff)) - 32'h10_0000) & ~32'd1;
        endcase
        return f;
    endfunction

    task automatic drive(input fields_t f, input logic last);
        bus.in_fmt = f.fmt; bus.in_opcode = f.opcode; bus.in_rd = f.rd;
        bus.in_rs1 = f.rs1; bus.in_rs2 = f.rs2; bus.in_funct3 = f.funct3;
        bus.in_funct7 = f.funct7; bus.in_imm = f.imm; bus.in_last = last;
    endtask

    task automatic do_reset_start();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        drive('0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Present one bundle, wait for acceptance and for its word; report latency.
    task automatic send_one(input fields_t f, input logic last,
                            output logic [31:0] instr, output logic [31:0] addr,
                            output logic err, output int lat, output bit tmo);
        int n;
        tmo = 0; n = 0;
        drive(f, last); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.in_ready) tmo = 1;
        @(posedge clk); #1 bus.in_valid = 1'b0; bus.in_last = 1'b0;
        lat = 1; @(negedge clk);
        while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!bus.out_valid) tmo = 1;
        instr = bus.out_instr; addr = bus.out_addr; err = bus.out_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drive('0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr: got %h expected 0", bus.out_instr); end
        n_cmp++; if (bus.out_addr !== BASE) begin n_err++; $display("FAIL rst_out_addr: got %h expected %h", bus.out_addr, BASE); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL rst_out_err: got %b expected 0", bus.out_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (instr_cnt !== 16'h0) begin n_err++; $display("FAIL rst_instr_cnt: got %0d expected 0", instr_cnt); end
        // Bundles offered while idle must not be taken.
        @(posedge clk); #1 rst = 1'b0; bus.in_valid = 1'b1;
        drive(mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
                begin n_err++; $display("FAIL idle_accept: in_ready=%b out_valid=%b expected 0/0", bus.in_ready, bus.out_valid); end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] instr, addr; logic err; int lat; bit tmo;
        do_reset_start();
        send_one(mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b0, instr, addr, err, lat, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL single_timeout: got timeout expected handshake"); end
        n_cmp++; if (instr !== 32'h0050_0093) begin n_err++; $display("FAIL single_instr: got %h expected 00500093", instr); end
        n_cmp++; if (addr !== BASE) begin n_err++; $display("FAIL single_addr: got %h expected %h", addr, BASE); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b expected 0", err); end
    endtask

    task automatic test_formats();
        fields_t tv_f[8]; logic [31:0] tv_i[8]; logic tv_e[8];
        logic [31:0] instr, addr; logic err; int lat; bit tmo;
        tv_f[0] = mk(FMT_B, OP_BRANCH, 5'd31, 5'd1, 5'd2, 3'd0, 7'h7f, 32'hffff_fff8); tv_i[0] = 32'hFE20_8CE3; tv_e[0] = 1'b0;
        tv_f[1] = mk(FMT_J, OP_JAL, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7f, 32'd2048);       tv_i[1] = 32'h0010_00EF; tv_e[1] = 1'b0;
        tv_f[2] = mk(FMT_U, OP_LUI, 5'd5, 5'd9, 5'd9, 3'd5, 7'h11, 32'h1234_5000);     tv_i[2] = 32'h1234_52B7; tv_e[2] = 1'b0;
        tv_f[3] = mk(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);           tv_i[3] = 32'h8000_0093; tv_e[3] = CHK;
        tv_f[4] = mk(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);           tv_i[4] = 32'h0020_8163; tv_e[4] = CHK;
        tv_f[5] = mk(3'd7, OP_JAL, 5'd3, 5'd3, 5'd3, 3'd3, 7'h3, 32'h1234_5678);       tv_i[5] = 32'h0000_0013; tv_e[5] = CHK;
        tv_f[6] = mk(FMT_S, OP_STORE, 5'd17, 5'd2, 5'd3, 3'd2, 7'h55, 32'hffff_fffc);  tv_i[6] = 32'hFE31_2E23; tv_e[6] = 1'b0;
        tv_f[7] = mk(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hdead_beef);      tv_i[7] = 32'h4020_81B3; tv_e[7] = 1'b0;
        do_reset_start();
        for (int k = 0; k < 8; k++) begin
            send_one(tv_f[k], 1'b0, instr, addr, err, lat, tmo);
            n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL fmt%0d_timeout: got timeout expected handshake", k); end
            n_cmp++; if (instr !== tv_i[k]) begin n_err++; $display("FAIL fmt%0d_instr: got %h expected %h", k, instr, tv_i[k]); end
            n_cmp++; if (err !== tv_e[k]) begin n_err++; $display("FAIL fmt%0d_err: got %b expected %b", k, err, tv_e[k]); end
            n_cmp++; if (addr !== BASE + 32'(4 * k)) begin n_err++; $display("FAIL fmt%0d_addr: got %h expected %h", k, addr, BASE + 32'(4 * k)); end
        end
    endtask

    task automatic test_backpressure();
        fields_t b[3]; logic [31:0] exp_i[$]; int acc = 0, got = 0, cyc = 0;
        for (int k = 0; k < 3; k++) begin b[k] = rand_fields(); exp_i.push_back(ref_encode(b[k])); end
        do_reset_start();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (acc < 3); drive(b[acc < 3 ? acc : 2], 1'b0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL bp_accepts: got %0d expected 2", acc); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        while (got < 3 && cyc < 50) begin
            bus.in_valid = (acc < 3); drive(b[acc < 3 ? acc : 2], 1'b0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++; if (bus.out_instr !== exp_i[got] || bus.out_addr !== BASE + 32'(4 * got))
                    begin n_err++; $display("FAIL bp_word%0d: got %h@%h expected %h@%h", got, bus.out_instr, bus.out_addr, exp_i[got], BASE + 32'(4 * got)); end
                got++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL bp_drain: got %0d words expected 3", got); end
    endtask

    task automatic test_done();
        int acc = 0, got = 0, cyc = 0;
        do_reset_start();
        bus.out_ready = 1'b1;
        while (got < 3 && cyc < 50) begin
            bus.in_valid = (acc < 3);
            drive(mk(FMT_I, OP_IMM, 5'(acc + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc)), acc == 2);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid && bus.out_ready) begin
                got++;
                if (got == 3) begin
                    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_early: got %b expected 0", done); end
                end
            end
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_pulse: got %b expected 1", done); end
        n_cmp++; if (instr_cnt !== 16'd3) begin n_err++; $display("FAIL done_cnt: got %0d expected 3", instr_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL done_busy: got %b expected 1", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL done_end: done=%b busy=%b expected 0/0", done, busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL done_extra: out_valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        do_reset_start();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        drive(mk(FMT_U, OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'habcd_e000), 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_err !== 1'b0)
            begin n_err++; $display("FAIL mid_rst_flags: out_valid=%b in_ready=%b err=%b expected 0/0/0", bus.out_valid, bus.in_ready, bus.out_err); end
        n_cmp++; if (bus.out_instr !== 32'h0 || bus.out_addr !== BASE)
            begin n_err++; $display("FAIL mid_rst_data: instr=%h addr=%h expected 0/%h", bus.out_instr, bus.out_addr, BASE); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || instr_cnt !== 16'd0)
            begin n_err++; $display("FAIL mid_rst_status: busy=%b done=%b cnt=%0d expected 0/0/0", busy, done, instr_cnt); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.out_valid) seen = 1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_emit: saw out_valid after reset expected none"); end
    endtask

    task automatic test_random();
        localparam int N = 80;
        fields_t cur; logic [31:0] exp_i[$], exp_a[$]; logic exp_e[$];
        logic [31:0] h_i, h_a; logic h_e; bit hold = 0;
        int sent = 0, got = 0, cyc = 0;
        cur = rand_fields();
        do_reset_start();
        while (got < N && cyc < 3000) begin
            bus.in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
            drive(cur, sent == N - 1);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (hold) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== h_i || bus.out_addr !== h_a || bus.out_err !== h_e)
                    begin n_err++; $display("FAIL rnd_hold: got v=%b %h@%h e=%b expected 1 %h@%h e=%b", bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, h_i, h_a, h_e); end
            end
            hold = bus.out_valid && !bus.out_ready;
            h_i = bus.out_instr; h_a = bus.out_addr; h_e = bus.out_err;
            if (bus.in_valid && bus.in_ready) begin
                exp_i.push_back(ref_encode(cur)); exp_e.push_back(ref_err(cur));
                exp_a.push_back(BASE + 32'(4 * sent));
                sent++; cur = rand_fields();
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_i.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra: got unexpected word %h expected none", bus.out_instr);
                end else if (bus.out_instr !== exp_i[0] || bus.out_addr !== exp_a[0] || bus.out_err !== exp_e[0]) begin
                    n_err++; $display("FAIL rnd_word%0d: got %h@%h e=%b expected %h@%h e=%b", got, bus.out_instr, bus.out_addr, bus.out_err, exp_i[0], exp_a[0], exp_e[0]);
                end
                if (exp_i.size() != 0) begin void'(exp_i.pop_front()); void'(exp_a.pop_front()); void'(exp_e.pop_front()); end
                got++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got !== N) begin n_err++; $display("FAIL rnd_count: got %0d words expected %0d", got, N); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || instr_cnt !== 16'(N)) begin n_err++; $display("FAIL rnd_end: busy=%b cnt=%0d expected 0/%0d", busy, instr_cnt, N); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        drive('0, 1'b0);
        test_reset();
        test_single();
        test_formats();
        test_backpressure();
        test_done();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
